lc3_mem_interface: RTL and testbench
====================================

Name: lc3_mem_interface

Overview:
Memory access stage directly downstream of the LC-3 control FSM. Owns MAR and MDR and drives the external memory handshake. It executes the MAR/MDR load strobes and read/write requests issued by the control FSM, and returns a ready pulse (R) so the FSM can hold its memory states. It drives MDR onto the processor bus when enabled.

Parameters:
DATA_W, 16, bus/data/address width
TIMEOUT, 255, max cycles waiting for mem_ack before aborting (1..65535)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
bus_in  in  DATA_W  processor bus value
ldMAR  in  1  MAR <= bus_in
ldMDR  in  1  MDR load strobe
selMDR  in  2  MDR source: 00 bus_in, 01 memory read result, others reserved (treated as 00)
memEN  in  1  start memory access (1-cycle pulse from control)
memWE  in  1  with memEN: 1 write M[MAR]<=MDR, 0 read
enaMDR  in  1  drive MDR onto mdr_out
mdr_out  out  DATA_W  MDR when enaMDR else 0
MAR  out  DATA_W  current MAR
MDR  out  DATA_W  current MDR
R  out  1  access complete, 1-cycle pulse
busy  out  1  access in flight
mem_err  out  1  sticky timeout flag
mem_req  out  1  external request
mem_we  out  1  external write enable
mem_addr  out  DATA_W  external address
mem_wdata  out  DATA_W  external write data
mem_rdata  in  DATA_W  external read data
mem_ack  in  1  external completion, valid for 1 cycle

Behaviour:
- Reset (reset==0 at posedge): MAR=0, MDR=0, R=0, busy=0, mem_err=0, mem_req=0, mem_we=0, state=IDLE. A reset mid-access abandons the access. A late mem_ack after reset is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - ldMAR loads MAR.
  - ldMDR with selMDR!=01 loads MDR from bus_in.
  - memEN: latch memWE, clear mem_err, mem_req=1, mem_we=memWE, mem_addr=MAR (value after any same-cycle ldMAR, i.e. bus_in if ldMAR=1), mem_wdata=MDR (same rule), go to ACCESS.
- ACCESS:
  - mem_req held high, address/data stable, busy=1, counter increments each cycle.
  - mem_ack=1: for reads, hold the data in a read buffer. Drop mem_req, go to DONE.
  - Counter reaches TIMEOUT without ack: drop mem_req, set mem_err, go to DONE. The read buffer is not updated.
- DONE:
  - R=1 for exactly this cycle, busy=0, return to IDLE.
  - ldMDR with selMDR=01 in DONE (or any later IDLE cycle) loads MDR from the read buffer.
- Minimum latency: memEN at cycle N, ack at N+1 gives R at N+2.
- Collisions:
  - ldMAR/ldMDR/memEN during ACCESS are ignored (MAR/MDR frozen while busy).
  - memEN in DONE is ignored.
  - ldMAR and ldMDR in the same IDLE cycle both take effect.
- mem_ack outside ACCESS is ignored.
- mdr_out is combinational: enaMDR ? MDR : 0.

Optional Feature:
LC3_MMIO_EN
- Defined: accesses with MAR >= 16'hFE00 are serviced internally and never assert mem_req.
  - Registers: KBSR FE00, KBDR FE02, DSR FE04, DDR FE06.
  - Ports added: kb_valid in 1, kb_data in 8, disp_ready in 1, disp_valid out 1, disp_data out 8.
  - kb_valid sets KBSR[15] and latches KBDR[7:0]; reading KBDR clears KBSR[15].
  - DSR[15] = disp_ready.
  - Writing DDR pulses disp_valid for 1 cycle with DDR[7:0].
  - MMIO access goes IDLE→DONE (R one cycle after memEN).
  - Unmapped FExx reads return 0; writes are dropped.
- Undefined: all addresses go external; the extra ports are absent.

Decomposition:
- Package lc3_pkg: state enum (IDLE/ACCESS/DONE), selMDR codes (SELMDR_BUS, SELMDR_MEM), MMIO address constants, DATA_W default.
- Sub-module lc3_mmio_regs holds the KBSR/KBDR/DSR/DDR logic, instantiated only under LC3_MMIO_EN.

Test Plan:
- Reset: drive reset=0 mid-ACCESS with MAR=0x3000 -> next cycle MAR=0, mem_req=0, busy=0. Late ack ignored; R never asserts.
- Read: ldMAR with bus_in=0x3000; memEN, memWE=0; ack 3 cycles later with mem_rdata=0x1234; then ldMDR with selMDR=01 -> mem_addr=0x3000 throughout, R single pulse, MDR=0x1234, enaMDR gives mdr_out=0x1234.
- Write: MAR=0x4000, MDR=0xBEEF; memEN, memWE=1; ack next cycle -> mem_we=1, mem_wdata=0xBEEF, R at N+2.
- Timeout: TIMEOUT=4, memEN, no ack -> mem_req deasserts after 4 cycles, mem_err=1, R pulses. Next memEN clears mem_err.
- Busy collision: ldMAR bus_in=0x5555 during ACCESS -> MAR unchanged, mem_addr stable.
- MMIO (LC3_MMIO_EN): kb_valid with kb_data=0x41; read FE00 -> bit15=1, no mem_req. Read FE02 -> 0x0041 and KBSR[15] cleared. Write FE06 = 0x0042 -> disp_valid pulse, disp_data=0x42.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory access stage and its optional
// memory-mapped I/O block.
package lc3_pkg;

    localparam int LC3_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SELMDR_BUS = 2'b00;
    localparam logic [1:0] SELMDR_MEM = 2'b01;

    localparam logic [15:0] MMIO_BASE = 16'hFE00;
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

endpackage

// File: rtl/lc3_mem_interface_if.sv
// External memory handshake: request/ack with address, write data and read data.
interface lc3_mem_interface_if #(
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lc3_mmio_regs.sv
// Keyboard/display device registers (KBSR, KBDR, DSR, DDR); the module only
// exists when LC3_MMIO_EN is defined.
`ifdef LC3_MMIO_EN
module lc3_mmio_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        acc,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    input  logic        disp_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data
);
    logic       kb_rdy;
    logic [7:0] kbdr;

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_KBSR: rdata = {kb_rdy, 15'd0};
            ADDR_KBDR: rdata = {8'd0, kbdr};
            ADDR_DSR:  rdata = {disp_ready, 15'd0};
            default:   rdata = '0;
        endcase
    end

    // A new key arriving in the same cycle as a KBDR read keeps the ready flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            kb_rdy     <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= acc && we && (addr == ADDR_DDR);
            if (kb_valid)
                kb_rdy <= 1'b1;
            else if (acc && !we && (addr == ADDR_KBDR))
                kb_rdy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (kb_valid)
            kbdr <= kb_data;
        if (acc && we && (addr == ADDR_DDR))
            disp_data <= wdata[7:0];
    end
endmodule
`endif

// File: rtl/lc3_mem_interface.sv
// LC-3 memory access stage: owns MAR/MDR and runs the external memory handshake.
// Define LC3_MMIO_EN to service FExx addresses internally via lc3_mmio_regs.
module lc3_mem_interface
    import lc3_pkg::*;
#(
    parameter int DATA_W  = LC3_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    lc3_mem_interface_if.master        mem,
    input  logic [DATA_W-1:0]          bus_in,
    input  logic                       ldMAR,
    input  logic                       ldMDR,
    input  logic [1:0]                 selMDR,
    input  logic                       memEN,
    input  logic                       memWE,
    input  logic                       enaMDR,
    output logic [DATA_W-1:0]          mdr_out,
    output logic [DATA_W-1:0]          MAR,
    output logic [DATA_W-1:0]          MDR,
    output logic                       R,
    output logic                       busy,
    output logic                       mem_err
`ifdef LC3_MMIO_EN
    ,
    input  logic                       kb_valid,
    input  logic [7:0]                 kb_data,
    input  logic                       disp_ready,
    output logic                       disp_valid,
    output logic [7:0]                 disp_data
`endif
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [15:0]       cnt;
    logic              we_q;
    logic              mmio_hit;
    logic              timeout_hit;
    logic [DATA_W-1:0] rd_buf;
    logic [DATA_W-1:0] mar_nx;
    logic [DATA_W-1:0] mdr_nx;

    // Values MAR/MDR take at the end of an IDLE cycle; a same-cycle memEN uses them.
    assign mar_nx      = ldMAR ? bus_in : MAR;
    assign mdr_nx      = !ldMDR ? MDR : ((selMDR == SELMDR_MEM) ? rd_buf : bus_in);
    assign timeout_hit = (cnt == TO_LAST);
    assign mdr_out     = enaMDR ? MDR : '0;

`ifdef LC3_MMIO_EN
    logic [15:0] mmio_rdata;
    logic        mmio_acc;

    assign mmio_hit = (mar_nx >= DATA_W'(MMIO_BASE));
    assign mmio_acc = (state == IDLE) && memEN && mmio_hit;

    lc3_mmio_regs u_mmio (
        .clk        (clk),
        .reset      (reset),
        .acc        (mmio_acc),
        .we         (memWE),
        .addr       (mar_nx[15:0]),
        .wdata      (mdr_nx[15:0]),
        .rdata      (mmio_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .disp_ready (disp_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
    );
`else
    assign mmio_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        R             = 1'b0;
        busy          = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = MAR;
        mem.mem_wdata = MDR;
        case (state)
            IDLE: begin
                if (memEN)
                    state_nx = mmio_hit ? DONE : ACCESS;
            end
            ACCESS: begin
                busy        = 1'b1;
                mem.mem_req = 1'b1;
                mem.mem_we  = we_q;
                if (mem.mem_ack || timeout_hit)
                    state_nx = DONE;
            end
            DONE: begin
                R        = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else if (state == IDLE && memEN) begin
            we_q    <= memWE;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 16'd1;
            if (!mem.mem_ack && timeout_hit)
                mem_err <= 1'b1;
        end
    end

    // MAR/MDR are frozen for the whole access; only the read buffer may load in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            MAR <= '0;
            MDR <= '0;
        end else if (state == IDLE) begin
            MAR <= mar_nx;
            MDR <= mdr_nx;
        end else if (state == DONE && ldMDR && selMDR == SELMDR_MEM) begin
            MDR <= rd_buf;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ACCESS && mem.mem_ack && !we_q)
            rd_buf <= mem.mem_rdata;
`ifdef LC3_MMIO_EN
        else if (mmio_acc && !memWE)
            rd_buf <= DATA_W'(mmio_rdata);
`endif
    end
endmodule

// File: tb/tb_lc3_mem_interface.sv
// Directed bench for lc3_mem_interface (TIMEOUT=4); MMIO steps run when LC3_MMIO_EN is defined.
module tb_lc3_mem_interface;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic        ldMAR, ldMDR, memEN, memWE, enaMDR;
    logic [1:0]  selMDR;
    logic [15:0] mdr_out, MAR, MDR;
    logic        R, busy, mem_err;
`ifdef LC3_MMIO_EN
    logic        kb_valid, disp_ready, disp_valid;
    logic [7:0]  kb_data, disp_data;
`endif
    int errors = 0;
    int checks = 0;

    lc3_mem_interface_if #(.DATA_W(16)) mem_if ();

    lc3_mem_interface #(.DATA_W(16), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mem_if),
        .bus_in     (bus_in),
        .ldMAR      (ldMAR),
        .ldMDR      (ldMDR),
        .selMDR     (selMDR),
        .memEN      (memEN),
        .memWE      (memWE),
        .enaMDR     (enaMDR),
        .mdr_out    (mdr_out),
        .MAR        (MAR),
        .MDR        (MDR),
        .R          (R),
        .busy       (busy),
        .mem_err    (mem_err)
`ifdef LC3_MMIO_EN
        ,
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .disp_ready (disp_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; bus_in = '0; ldMAR = 0; ldMDR = 0; selMDR = 2'b00;
        memEN = 0; memWE = 0; enaMDR = 0;
        mem_if.mem_ack = 0; mem_if.mem_rdata = '0;
`ifdef LC3_MMIO_EN
        kb_valid = 0; kb_data = '0; disp_ready = 0;
`endif
        tick(); tick();
        check("rst_mar", MAR, 0);
        check("rst_mdr", MDR, 0);
        check("rst_r", R, 0);
        check("rst_busy", busy, 0);
        check("rst_err", mem_err, 0);
        check("rst_req", mem_if.mem_req, 0);
        check("rst_we", mem_if.mem_we, 0);
        reset = 1'b1;

        // Read with ack three cycles after memEN
        bus_in = 16'h3000; ldMAR = 1; tick(); ldMAR = 0;
        check("rd_mar", MAR, 16'h3000);
        memEN = 1; memWE = 0; tick(); memEN = 0;
        check("rd_req", mem_if.mem_req, 1);
        check("rd_busy", busy, 1);
        check("rd_we", mem_if.mem_we, 0);
        check("rd_addr1", mem_if.mem_addr, 16'h3000);
        check("rd_r_early", R, 0);
        tick(); tick();
        check("rd_addr3", mem_if.mem_addr, 16'h3000);
        check("rd_req3", mem_if.mem_req, 1);
        mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h1234; tick(); mem_if.mem_ack = 0;
        check("rd_r", R, 1);
        check("rd_done_req", mem_if.mem_req, 0);
        check("rd_done_busy", busy, 0);
        ldMDR = 1; selMDR = 2'b01; tick(); ldMDR = 0; selMDR = 2'b00;
        check("rd_r_single", R, 0);
        check("rd_mdr", MDR, 16'h1234);
        enaMDR = 1; #1;
        check("rd_mdr_out", mdr_out, 16'h1234);
        enaMDR = 0; #1;
        check("rd_mdr_out_off", mdr_out, 0);

        // Write with ack on the first ACCESS cycle
        bus_in = 16'h4000; ldMAR = 1; tick(); ldMAR = 0;
        bus_in = 16'hBEEF; ldMDR = 1; tick(); ldMDR = 0;
        check("wr_mdr", MDR, 16'hBEEF);
        memEN = 1; memWE = 1; tick(); memEN = 0; memWE = 0;
        check("wr_we", mem_if.mem_we, 1);
        check("wr_wdata", mem_if.mem_wdata, 16'hBEEF);
        check("wr_addr", mem_if.mem_addr, 16'h4000);
        mem_if.mem_ack = 1; tick(); mem_if.mem_ack = 0;
        check("wr_r", R, 1);
        tick();
        check("wr_r_off", R, 0);

        // Same-cycle ldMAR+memEN, busy collision, then timeout
        bus_in = 16'h5000; ldMAR = 1; memEN = 1; memWE = 0; tick(); memEN = 0;
        check("col_addr", mem_if.mem_addr, 16'h5000);
        bus_in = 16'h5555; ldMDR = 1; tick(); ldMAR = 0; ldMDR = 0;
        check("col_mar", MAR, 16'h5000);
        check("col_addr2", mem_if.mem_addr, 16'h5000);
        check("col_mdr", MDR, 16'hBEEF);
        tick(); tick();
        check("to_req4", mem_if.mem_req, 1);
        tick();
        check("to_req_drop", mem_if.mem_req, 0);
        check("to_err", mem_err, 1);
        check("to_r", R, 1);
        tick();
        check("to_err_sticky", mem_err, 1);
        check("to_r_off", R, 0);

        // Next access clears mem_err; reset mid-access abandons it
        bus_in = 16'h3000; ldMAR = 1; memEN = 1; tick(); ldMAR = 0; memEN = 0;
        check("clr_err", mem_err, 0);
        check("rs_busy_pre", busy, 1);
        check("rs_mar_pre", MAR, 16'h3000);
        reset = 1'b0; tick(); reset = 1'b1;
        check("rs_mar", MAR, 0);
        check("rs_req", mem_if.mem_req, 0);
        check("rs_busy", busy, 0);
        mem_if.mem_ack = 1; mem_if.mem_rdata = 16'hFFFF; tick(); mem_if.mem_ack = 0;
        check("late_ack_r", R, 0);
        check("late_ack_busy", busy, 0);
        tick();
        check("late_ack_r2", R, 0);
        // Read buffer still holds the last acknowledged read
        ldMDR = 1; selMDR = 2'b01; tick(); ldMDR = 0; selMDR = 2'b00;
        check("rdbuf_kept", MDR, 16'h1234);

`ifdef LC3_MMIO_EN
        kb_valid = 1; kb_data = 8'h41; tick(); kb_valid = 0;
        bus_in = 16'hFE00; ldMAR = 1; memEN = 1; memWE = 0; tick(); ldMAR = 0; memEN = 0;
        check("mmio_kbsr_r", R, 1);
        check("mmio_kbsr_req", mem_if.mem_req, 0);
        ldMDR = 1; selMDR = 2'b01; tick(); ldMDR = 0; selMDR = 2'b00;
        check("mmio_kbsr", MDR, 16'h8000);
        bus_in = 16'hFE02; ldMAR = 1; memEN = 1; tick(); ldMAR = 0; memEN = 0;
        check("mmio_kbdr_req", mem_if.mem_req, 0);
        ldMDR = 1; selMDR = 2'b01; tick(); ldMDR = 0; selMDR = 2'b00;
        check("mmio_kbdr", MDR, 16'h0041);
        bus_in = 16'hFE00; ldMAR = 1; memEN = 1; tick(); ldMAR = 0; memEN = 0;
        ldMDR = 1; selMDR = 2'b01; tick(); ldMDR = 0; selMDR = 2'b00;
        check("mmio_kbsr_clr", MDR, 16'h0000);
        bus_in = 16'h0042; ldMDR = 1; tick(); ldMDR = 0;
        bus_in = 16'hFE06; ldMAR = 1; memEN = 1; memWE = 1; tick();
        ldMAR = 0; memEN = 0; memWE = 0;
        check("mmio_ddr_valid", disp_valid, 1);
        check("mmio_ddr_data", disp_data, 8'h42);
        check("mmio_ddr_req", mem_if.mem_req, 0);
        tick();
        check("mmio_ddr_pulse", disp_valid, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
